bench_bist_ctrl: RTL and testbench

Built-in self-test driver that sits at the opposite end of a benchmark core's I/O, e.g. the s526-class cores in syn/rtl.
- Generates pseudo-random primary-input patterns with an LFSR.
- Holds the core in reset, then releases it and runs a fixed number of pattern cycles.
- Compacts the core's primary outputs into a MISR signature and compares it against a golden value.
- Gives the clock-mesh flow a self-checking, activity-rich top for gate-level and timing sign-off.

---
 rtl/bench_bist_pkg.sv | 24 ++
 rtl/bist_lfsr16.sv | 32 +++
 rtl/bench_bist_ctrl.sv | 159 +++++++++++++++
 tb/tb_bench_bist_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bench_bist_pkg.sv
// rtl/bench_bist_pkg.sv - shared types and constants for the BIST controller
package bench_bist_pkg;

    localparam int LFSR_W = 16;

    // Feedback taps at bits 15, 13, 12 and 10, shared by the TPG and the MISR
    localparam logic [LFSR_W-1:0] POLY_TAPS = 16'hB400;

    // Core reset is held for this many cycles before patterns start
    localparam int DRST_CYCLES = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRST,
        S_RUN,
        S_FLUSH,
        S_DONE
    } bist_state_e;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] v);
        return ^(v & POLY_TAPS);
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// rtl/bist_lfsr16.sv - 16-bit Fibonacci shift register usable as TPG or MISR
module bist_lfsr16
    import bench_bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              en,
    input  logic              mode,
    input  logic [LFSR_W-1:0] data,
    output logic [LFSR_W-1:0] q,
    output logic [LFSR_W-1:0] nxt
);

    // In MISR mode the parallel data word is folded into the shifted value
    assign nxt = {q[LFSR_W-2:0], lfsr_fb(q)} ^ (mode ? data : '0);

    // Load has priority over stepping so a new run always starts from seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= INIT;
        end else if (load) begin
            q <= seed;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/bench_bist_ctrl.sv
// rtl/bench_bist_ctrl.sv - BIST driver: LFSR stimulus, core reset sequencing, MISR check
module bench_bist_ctrl
    import bench_bist_pkg::*;
#(
    parameter int                PI_W       = 3,
    parameter int                PO_W       = 6,
    parameter int                NPAT       = 1000,
    parameter int                CAPT_LAT   = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1,
    parameter logic [LFSR_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic              abort,
    input  logic [PO_W-1:0]   po_in,
    output logic [PI_W-1:0]   pi_out,
    output logic              dut_rst,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [LFSR_W-1:0] signature
);

    localparam int CNT_W = $clog2(NPAT + CAPT_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_DRST  = CNT_W'(DRST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_RUN   = CNT_W'(NPAT - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(NPAT + CAPT_LAT - 1);
    localparam logic [CNT_W-1:0] FIRST_CAPT = CNT_W'(CAPT_LAT);

    bist_state_e       state;
    logic [CNT_W-1:0]  count;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [LFSR_W-1:0] misr_q;
    logic [LFSR_W-1:0] misr_nxt;
    logic              active;
    logic              do_abort;
    logic              do_start;
    logic              tpg_en;
    logic              misr_en;
    logic              unused_bits;

    assign active   = (state == S_DRST) || (state == S_RUN) || (state == S_FLUSH);
    assign do_abort = abort && active;
    assign do_start = start && !active;

    // The TPG steps on the RUN entry edge and on every RUN edge but the last,
    // so each RUN cycle presents a fresh pattern and exactly NPAT are produced
    assign tpg_en = !do_abort &&
                    (((state == S_DRST) && (count == LAST_DRST)) ||
                     ((state == S_RUN) && (count != LAST_RUN)));

    // Responses lag their pattern by CAPT_LAT, so the window is shifted into FLUSH
    assign misr_en = !do_abort &&
                     ((state == S_RUN) || (state == S_FLUSH)) &&
                     (count >= FIRST_CAPT);

    bist_lfsr16 #(.INIT(LFSR_SEED)) u_tpg (
        .clk   (blif_clk_net),
        .rst_n (blif_reset_net),
        .load  (do_start),
        .seed  (LFSR_SEED),
        .en    (tpg_en),
        .mode  (1'b0),
        .data  ('0),
        .q     (lfsr_q),
        .nxt   (lfsr_nxt)
    );

    bist_lfsr16 #(.INIT('0)) u_misr (
        .clk   (blif_clk_net),
        .rst_n (blif_reset_net),
        .load  (do_start),
        .seed  ('0),
        .en    (misr_en),
        .mode  (1'b1),
        .data  (LFSR_W'(po_in)),
        .q     (misr_q),
        .nxt   (misr_nxt)
    );

    assign signature = misr_q;

    // Only the low TPG bits drive the core; the rest are intentionally dropped
    assign unused_bits = ^{lfsr_q, lfsr_nxt};

    // Run sequencer; abort while active overrides whatever the state would do
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state   <= S_IDLE;
            count   <= '0;
            pi_out  <= '0;
            dut_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_DRST;
                        count   <= '0;
                        pi_out  <= '0;
                        dut_rst <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end
                end
                S_DRST: begin
                    if (count == LAST_DRST) begin
                        state   <= S_RUN;
                        count   <= '0;
                        dut_rst <= 1'b0;
                        pi_out  <= lfsr_q[PI_W-1:0];
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end
                S_RUN: begin
                    count <= count + CNT_ONE;
                    if (count == LAST_RUN) begin
                        state  <= S_FLUSH;
                        pi_out <= '0;
                    end else begin
                        pi_out <= lfsr_q[PI_W-1:0];
                    end
                end
                S_FLUSH: begin
                    if (count == LAST_FLUSH) begin
                        state   <= S_DONE;
                        count   <= '0;
                        dut_rst <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (misr_nxt == GOLDEN_SIG);
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (do_abort) begin
                state   <= S_IDLE;
                count   <= '0;
                pi_out  <= '0;
                dut_rst <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b0;
                pass    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bench_bist_ctrl.sv
// tb/tb_bench_bist_ctrl.sv - self-checking bench for bench_bist_ctrl
module tb_bench_bist_ctrl;

    localparam int N0 = 4;
    localparam int C0 = 1;
    localparam int N1 = 12;
    localparam int C1 = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_v [2];
    logic        abort_v [2];
    logic [5:0]  po_v [2];
    logic [2:0]  pi_v [2];
    logic        dut_rst_v [2];
    logic        busy_v [2];
    logic        done_v [2];
    logic        pass_v [2];
    logic [15:0] sig_v [2];

    int checks = 0;
    int errors = 0;
    logic [2:0] pi_q [$];

    typedef struct packed {
        logic [23:0] po;
        logic [15:0] sig;
        logic        pass;
        logic        noise;
        logic        both;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    bench_bist_ctrl #(
        .PI_W(3), .PO_W(6), .NPAT(N0), .CAPT_LAT(C0),
        .LFSR_SEED(SEED), .GOLDEN_SIG(16'h0000)
    ) dut0 (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .start          (start_v[0]),
        .abort          (abort_v[0]),
        .po_in          (po_v[0]),
        .pi_out         (pi_v[0]),
        .dut_rst        (dut_rst_v[0]),
        .busy           (busy_v[0]),
        .done           (done_v[0]),
        .pass           (pass_v[0]),
        .signature      (sig_v[0])
    );

    bench_bist_ctrl #(
        .PI_W(3), .PO_W(6), .NPAT(N1), .CAPT_LAT(C1),
        .LFSR_SEED(SEED), .GOLDEN_SIG(16'h0000)
    ) dut1 (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .start          (start_v[1]),
        .abort          (abort_v[1]),
        .po_in          (po_v[1]),
        .pi_out         (pi_v[1]),
        .dut_rst        (dut_rst_v[1]),
        .busy           (busy_v[1]),
        .done           (done_v[1]),
        .pass           (pass_v[1]),
        .signature      (sig_v[1])
    );

    function automatic logic [15:0] step(input logic [15:0] v, input logic [15:0] d);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]} ^ d;
    endfunction

    function automatic logic [15:0] misr_of(input logic [95:0] pos, input int n);
        logic [15:0] m = 16'h0;
        for (int i = 0; i < n; i++) m = step(m, 16'(pos[6*i +: 6]));
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input int d);
        chk("reset_ctl", 32'({pi_v[d], dut_rst_v[d], busy_v[d], done_v[d], pass_v[d]}),
            32'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        chk("reset_sig", 32'(sig_v[d]), 32'h0);
    endtask

    // One run on DUT d. Cycle t counts from the edge that takes start (t=0,1 DRST,
    // then NPAT RUN cycles, CAPT_LAT FLUSH cycles, then DONE). po carries the real
    // response only inside the compaction window and random junk elsewhere.
    task automatic run(input int d, input logic [95:0] pos, input logic [15:0] exp_sig,
                       input logic exp_pass, input int abort_at, input int rst_at,
                       input logic noise, input logic both);
        int npat = (d == 0) ? N0 : N1;
        int capt = (d == 0) ? C0 : C1;
        logic [15:0] l = SEED;
        logic [15:0] m = 16'h0;
        logic [2:0]  epi;
        logic [5:0]  ectl;
        int k;
        for (int i = 0; i < npat; i++) begin
            pi_q.push_back(l[2:0]);
            l = step(l, 16'h0);
        end
        @(negedge clk);
        start_v[d] = 1'b1;
        abort_v[d] = both;
        for (int t = 0; t <= npat + capt + 2; t++) begin
            @(negedge clk);
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
            k = t - 2;
            epi = 3'd0;
            if (k >= 0 && k < npat) epi = pi_q.pop_front();
            if (t < 2)                 ectl = {1'b1, 1'b1, 1'b0, 3'd0};
            else if (k < npat)         ectl = {1'b0, 1'b1, 1'b0, epi};
            else if (k < npat + capt)  ectl = {1'b0, 1'b1, 1'b0, 3'd0};
            else                       ectl = {1'b1, 1'b0, 1'b1, 3'd0};
            chk("ctl", 32'({dut_rst_v[d], busy_v[d], done_v[d], pi_v[d]}), 32'(ectl));
            chk("sig_run", 32'(sig_v[d]), 32'(m));
            if (t == npat + capt + 2) begin
                chk("final_sig", 32'(sig_v[d]), 32'(exp_sig));
                chk("final_pass", 32'(pass_v[d]), 32'(exp_pass));
                chk("sb_empty", pi_q.size(), 32'd0);
            end
            if (t == abort_at) begin
                abort_v[d] = 1'b1;
                start_v[d] = noise;
                @(negedge clk);
                abort_v[d] = 1'b0;
                start_v[d] = 1'b0;
                chk("abort_ctl", 32'({pi_v[d], dut_rst_v[d], busy_v[d], done_v[d], pass_v[d]}),
                    32'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
                chk("abort_sig", 32'(sig_v[d]), 32'(m));
                pi_q.delete();
                return;
            end
            if (t == rst_at) begin
                #2 rst_n = 1'b0;
                #1 chk_reset(d);
                @(negedge clk);
                chk_reset(d);
                rst_n = 1'b1;
                pi_q.delete();
                return;
            end
            if (k >= capt && k < npat + capt) begin
                po_v[d] = pos[6*(k-capt) +: 6];
                m = step(m, 16'(po_v[d]));
            end else begin
                po_v[d] = 6'($urandom);
            end
            if (noise && k >= 0 && k < npat) start_v[d] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        logic [95:0] pos;
        logic [15:0] e;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
            po_v[d] = 6'd0;
        end
        vecs[0] = '{24'h000000, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{24'h000001, 16'h0008, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{24'h040000, 16'h0001, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{24'h00003F, 16'h01F8, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{24'h204081, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{24'h00003F, 16'h01F8, 1'b0, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;

        // Plain run from IDLE: zero responses match the zero golden value
        run(0, '0, 16'h0000, 1'b1, -1, -1, 1'b0, 1'b0);

        // Table of response patterns, each started from DONE (back-to-back)
        for (int i = 0; i < 6; i++)
            run(0, {72'h0, vecs[i].po}, vecs[i].sig, vecs[i].pass, -1, -1,
                vecs[i].noise, vecs[i].both);

        // Abort in DONE is ignored and done/pass/signature stay put
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk("done_sticky", 32'({dut_rst_v[0], busy_v[0], done_v[0], pass_v[0]}),
            32'({1'b1, 1'b0, 1'b1, vecs[5].pass}));
        chk("done_sig", 32'(sig_v[0]), 32'(vecs[5].sig));

        // Abort in RUN cycle 2 (with a simultaneous start), then a clean rerun
        run(0, '0, 16'h0000, 1'b1, 2 + 2, -1, 1'b1, 1'b0);
        run(0, {72'h0, 24'h000001}, 16'h0008, 1'b0, -1, -1, 1'b0, 1'b0);

        // Asynchronous reset in FLUSH, then a run after release
        run(0, {72'h0, 24'h204081}, 16'h0000, 1'b1, -1, 2 + N0, 1'b1, 1'b0);
        chk_reset(1);
        run(0, {72'h0, 24'h00003F}, 16'h01F8, 1'b0, -1, -1, 1'b0, 1'b0);

        // Longer runs with CAPT_LAT=2 so the MISR feedback taps come into play
        for (int r = 0; r < 5; r++) begin
            pos = (r == 0) ? '0 : {$urandom, $urandom, $urandom};
            e = misr_of(pos, N1);
            run(1, pos, e, (e == 16'h0000), (r == 3) ? (2 + N1 + 1) : -1, -1,
                1'(r % 2), (r == 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
